// File: rtl/lcd_sched.sv
// ============================================================================
// Module   : lcd_sched
// Purpose  : Round-robin scheduler sharing one two-digit 7-segment decoder
//            across the seconds, minutes and hours display fields.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_sched #(
    parameter int DWELL = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [6:0] Sec,
    input  logic [6:0] Min,
    input  logic [6:0] Hrs,
    input  logic [2:0] Blank,
    input  logic       Freeze,
    input  logic [6:0] Dec_seg1,
    input  logic [6:0] Dec_seg0,
    output logic [6:0] Dec_bin,
    output logic [6:0] SecSeg1,
    output logic [6:0] SecSeg0,
    output logic [6:0] MinSeg1,
    output logic [6:0] MinSeg0,
    output logic [6:0] HrsSeg1,
    output logic [6:0] HrsSeg0,
    output logic       Frame
);

    localparam logic [3:0] c_dwell   = 4'(DWELL);
    localparam logic [6:0] c_max_bin = 7'd99;

    typedef enum logic [1:0] {
        ST_SAMPLE  = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t          r_state;
    logic [1:0]      r_fp;
    logic [3:0]      r_cnt;
    logic [6:0]      r_bin;
    logic [2:0][6:0] r_seg1;
    logic [2:0][6:0] r_seg0;
    logic            r_frame;

    logic [6:0]      w_field;
    logic            w_blank;
    logic            w_zero;

    always_comb begin
        w_field = Hrs;
        w_blank = Blank[2];
        case (r_fp)
            2'd0: begin
                w_field = Sec;
                w_blank = Blank[0];
            end
            2'd1: begin
                w_field = Min;
                w_blank = Blank[1];
            end
            default: ;
        endcase
    end

    // Out-of-range values are blanked regardless of what the decoder shows.
    assign w_zero = w_blank | (r_bin > c_max_bin);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_SAMPLE;
            r_fp    <= 2'd0;
            r_cnt   <= 4'd0;
            r_bin   <= 7'd0;
            r_seg1  <= '0;
            r_seg0  <= '0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            case (r_state)
                ST_SAMPLE: begin
                    if (!Freeze) begin
                        r_bin   <= w_field;
                        r_cnt   <= c_dwell;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    for (int f = 0; f < 3; f++) begin
                        if (r_fp == 2'(f)) begin
                            r_seg1[f] <= w_zero ? 7'h00 : Dec_seg1;
                            r_seg0[f] <= w_zero ? 7'h00 : Dec_seg0;
                        end
                    end
                    r_fp    <= (r_fp == 2'd2) ? 2'd0 : r_fp + 2'd1;
                    r_frame <= (r_fp == 2'd2);
                    r_state <= ST_SAMPLE;
                end
                default: r_state <= ST_SAMPLE;
            endcase
        end
    end

    assign Dec_bin = r_bin;
    assign SecSeg1 = r_seg1[0];
    assign SecSeg0 = r_seg0[0];
    assign MinSeg1 = r_seg1[1];
    assign MinSeg0 = r_seg0[1];
    assign HrsSeg1 = r_seg1[2];
    assign HrsSeg0 = r_seg0[2];
    assign Frame   = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_lcd_sched.sv
// ============================================================================
// Module   : tb_lcd_sched
// Purpose  : Self-checking bench for lcd_sched at DWELL = 4, 1 and 15.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_sched;

    logic            Clk;
    logic            Reset_n;
    logic [6:0]      Sec, Min, Hrs;
    logic [2:0]      Blank;
    logic            Freeze;

    logic [2:0][6:0] dec_bin, dseg1, dseg0;
    logic [2:0][6:0] sec1, sec0, min1, min0, hrs1, hrs0;
    logic [2:0]      frame;

    int tests = 0;
    int fails = 0;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;
            3: return 7'h79;  4: return 7'h33;  5: return 7'h5B;
            6: return 7'h5F;  7: return 7'h70;  8: return 7'h7F;
            9: return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int dw_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 15;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int DW = (k == 0) ? 4 : (k == 1) ? 1 : 15;
        // Stand-in for lcd_int: decodes even out-of-range values to non-zero digits.
        assign dseg1[k] = seg7((int'(dec_bin[k]) / 10) % 10);
        assign dseg0[k] = seg7(int'(dec_bin[k]) % 10);
        lcd_sched #(.DWELL(DW)) u_dut (
            .Clk(Clk), .Reset_n(Reset_n), .Sec(Sec), .Min(Min), .Hrs(Hrs),
            .Blank(Blank), .Freeze(Freeze),
            .Dec_seg1(dseg1[k]), .Dec_seg0(dseg0[k]), .Dec_bin(dec_bin[k]),
            .SecSeg1(sec1[k]), .SecSeg0(sec0[k]), .MinSeg1(min1[k]),
            .MinSeg0(min0[k]), .HrsSeg1(hrs1[k]), .HrsSeg0(hrs0[k]),
            .Frame(frame[k])
        );
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference: m_pos counts edges since the field was sampled (0 = awaiting sample).
    int         m_pos[3];
    int         m_fp[3];
    logic [6:0] m_bin[3];
    logic [6:0] m_s1[3][3];
    logic [6:0] m_s0[3][3];
    logic       m_frame[3];

    function automatic logic [6:0] field_val(input int f);
        return (f == 0) ? Sec : (f == 1) ? Min : Hrs;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_pos[i]   <= 0;
                m_fp[i]    <= 0;
                m_bin[i]   <= 7'd0;
                m_frame[i] <= 1'b0;
                for (int f = 0; f < 3; f++) begin
                    m_s1[i][f] <= 7'h00;
                    m_s0[i][f] <= 7'h00;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_frame[i] <= 1'b0;
                if (m_pos[i] == 0) begin
                    if (!Freeze) begin
                        m_bin[i] <= field_val(m_fp[i]);
                        m_pos[i] <= 1;
                    end
                end else if (m_pos[i] <= dw_of(i)) begin
                    m_pos[i] <= m_pos[i] + 1;
                end else begin
                    if (Blank[m_fp[i]] || m_bin[i] > 7'd99) begin
                        m_s1[i][m_fp[i]] <= 7'h00;
                        m_s0[i][m_fp[i]] <= 7'h00;
                    end else begin
                        m_s1[i][m_fp[i]] <= seg7(int'(m_bin[i]) / 10);
                        m_s0[i][m_fp[i]] <= seg7(int'(m_bin[i]) % 10);
                    end
                    m_fp[i]    <= (m_fp[i] + 1) % 3;
                    m_pos[i]   <= 0;
                    m_frame[i] <= (m_fp[i] == 2);
                end
            end
        end
    end

    task automatic cmp(input string name, input int i, input logic [6:0] act,
                       input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 50)
                $display("FAIL %s[dut%0d] at %0t: got %h, expected %h", name, i, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            cmp("dec_bin", i, dec_bin[i], m_bin[i]);
            cmp("sec_seg1", i, sec1[i], m_s1[i][0]);
            cmp("sec_seg0", i, sec0[i], m_s0[i][0]);
            cmp("min_seg1", i, min1[i], m_s1[i][1]);
            cmp("min_seg0", i, min0[i], m_s0[i][1]);
            cmp("hrs_seg1", i, hrs1[i], m_s1[i][2]);
            cmp("hrs_seg0", i, hrs0[i], m_s0[i][2]);
            cmp("frame", i, {6'd0, frame[i]}, {6'd0, m_frame[i]});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
            compare_all();
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        tick(2);
        Reset_n = 1'b1;
    endtask

    task automatic lit_pair(input string name, input logic [6:0] a1, input logic [6:0] a0,
                            input logic [6:0] e1, input logic [6:0] e0);
        cmp({name, "_1"}, 0, a1, e1);
        cmp({name, "_0"}, 0, a0, e0);
    endtask

    function automatic logic [6:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 7'd99;
            1: return 7'd100;
            2: return 7'd0;
            3: return 7'd127;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    logic [6:0] bnd_val[4];
    logic [6:0] bnd_exp[4];

    initial begin
        Reset_n = 1'b0;
        Sec = 7'd56; Min = 7'd34; Hrs = 7'd12;
        Blank = 3'b000; Freeze = 1'b0;
        bnd_val = '{7'd99, 7'd0, 7'd100, 7'd127};
        bnd_exp = '{7'h7B, 7'h7E, 7'h00, 7'h00};
        tick(2);
        lit_pair("rst_sec", sec1[0], sec0[0], 7'h00, 7'h00);
        lit_pair("rst_hrs", hrs1[0], hrs0[0], 7'h00, 7'h00);
        cmp("rst_dec_bin", 0, dec_bin[0], 7'd0);
        cmp("rst_frame", 0, {6'd0, frame[0]}, 7'd0);
        Reset_n = 1'b1;

        // Basic refresh at all three dwell settings
        tick(1);
        cmp("e1_dec_bin", 0, dec_bin[0], 7'd56);
        cmp("e1_dec_bin", 2, dec_bin[2], 7'd56);
        tick(5);
        lit_pair("e6_sec", sec1[0], sec0[0], 7'h5B, 7'h5F);
        tick(3);
        cmp("e9_frame", 1, {6'd0, frame[1]}, 7'd1);
        tick(3);
        lit_pair("e12_min", min1[0], min0[0], 7'h79, 7'h33);
        tick(6);
        lit_pair("e18_hrs", hrs1[0], hrs0[0], 7'h30, 7'h6D);
        cmp("e18_frame", 0, {6'd0, frame[0]}, 7'd1);
        tick(1);
        cmp("e19_frame", 0, {6'd0, frame[0]}, 7'd0);
        tick(17);
        cmp("e36_frame", 0, {6'd0, frame[0]}, 7'd1);
        tick(15);
        cmp("e51_frame", 2, {6'd0, frame[2]}, 7'd1);

        // Sec changes while its value is settling
        do_reset();
        tick(2);
        Sec = 7'd57;
        tick(4);
        lit_pair("mid_sec_old", sec1[0], sec0[0], 7'h5B, 7'h5F);
        tick(18);
        lit_pair("mid_sec_new", sec1[0], sec0[0], 7'h5B, 7'h70);

        // Boundary values
        for (int b = 0; b < 4; b++) begin
            Sec = bnd_val[b];
            tick(110);
            lit_pair("bnd_sec", sec1[0], sec0[0], bnd_exp[b], bnd_exp[b]);
            lit_pair("bnd_min", min1[0], min0[0], 7'h79, 7'h33);
        end

        // Blank mask
        Sec = 7'd56;
        Blank = 3'b010;
        tick(110);
        lit_pair("blank_min", min1[0], min0[0], 7'h00, 7'h00);
        lit_pair("blank_sec", sec1[0], sec0[0], 7'h5B, 7'h5F);
        lit_pair("blank_hrs", hrs1[0], hrs0[0], 7'h30, 7'h6D);
        Blank = 3'b000;
        tick(110);
        lit_pair("unblank_min", min1[0], min0[0], 7'h79, 7'h33);

        // Freeze during Min WAIT
        do_reset();
        tick(8);
        Freeze = 1'b1;
        tick(4);
        lit_pair("frz_min", min1[0], min0[0], 7'h79, 7'h33);
        tick(5);
        cmp("frz_dec_bin", 0, dec_bin[0], 7'd34);
        cmp("frz_frame", 0, {6'd0, frame[0]}, 7'd0);
        lit_pair("frz_hrs", hrs1[0], hrs0[0], 7'h00, 7'h00);
        Freeze = 1'b0;
        tick(1);
        cmp("unfrz_dec_bin", 0, dec_bin[0], 7'd12);
        tick(5);
        lit_pair("unfrz_hrs", hrs1[0], hrs0[0], 7'h30, 7'h6D);
        cmp("unfrz_frame", 0, {6'd0, frame[0]}, 7'd1);

        // Asynchronous reset during Hrs WAIT
        do_reset();
        tick(14);
        #1 Reset_n = 1'b0;
        #1;
        lit_pair("arst_sec", sec1[0], sec0[0], 7'h00, 7'h00);
        lit_pair("arst_min", min1[0], min0[0], 7'h00, 7'h00);
        cmp("arst_dec_bin", 0, dec_bin[0], 7'd0);
        cmp("arst_frame", 0, {6'd0, frame[0]}, 7'd0);
        tick(2);
        Reset_n = 1'b1;
        tick(6);
        lit_pair("arst_sec_first", sec1[0], sec0[0], 7'h5B, 7'h5F);
        lit_pair("arst_min_wait", min1[0], min0[0], 7'h00, 7'h00);

        // Randomized traffic against the reference
        repeat (600) begin
            if ($urandom_range(0, 3) == 0) Sec = rand_val();
            if ($urandom_range(0, 3) == 0) Min = rand_val();
            if ($urandom_range(0, 3) == 0) Hrs = rand_val();
            if ($urandom_range(0, 7) == 0) Blank = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) Freeze = ~Freeze;
            if ($urandom_range(0, 199) == 0) begin
                Reset_n = 1'b0;
                tick(1);
                Reset_n = 1'b1;
            end
            tick(1);
        end
        Freeze = 1'b0;
        tick(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
